mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

- Shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data reads/writes) of the 5-stage RISC-V pipeline.
- Priority goes to the data side, with an anti-starvation counter that protects fetch.
- Produces per-stage stall signals for the pipeline registers.
- A watchdog terminates memory transactions that never complete and raises a sticky error.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive D grants allowed while I waits (>=1)
- TIMEOUT, 255, max wait cycles for mem_ack (>=1)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- i_req  in  1  fetch read request; held with i_addr stable until i_ready
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetch read data, valid when i_ready
- i_ready  out  1  fetch transaction complete (1-cycle)
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ready
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  data read data, valid when d_ready
- d_ready  out  1  data transaction complete (1-cycle)
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  memory completes the current transaction this cycle
- stall_F  out  1  i_req & ~i_ready
- stall_M  out  1  d_req & ~d_ready
- busy  out  1  state != IDLE
- grant_d  out  1  the current/last grant went to the data side
- err  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE, neither request: stay. mem_req = 0.
- IDLE, only d_req: go to BUSY_D. Register mem_we = d_we, mem_addr = d_addr, mem_wdata = d_wdata. Set grant_d = 1.
- IDLE, only i_req: go to BUSY_I. Register mem_we = 0, mem_addr = i_addr, mem_wdata = 0. Set grant_d = 0.
- IDLE, both requests: grant D unless starve_cnt == STARVE_LIMIT, in which case grant I.
- starve_cnt update:
  - increments on a D grant while i_req = 1 (saturates at STARVE_LIMIT)
  - clears on any I grant
  - clears on a D grant while i_req = 0
- BUSY_x: mem_req = 1 and mem_* stay stable.
  - On mem_ack: x_ready = 1 combinationally in the same cycle, x_rdata = mem_rdata (0 for writes), next state IDLE.
  - mem_ack while in IDLE is ignored.
- Watchdog: wait_cnt clears on entry to BUSY_x and increments each BUSY cycle without mem_ack.
  - When wait_cnt == TIMEOUT with no ack: x_ready = 1, x_rdata = 0, err set (sticky), next state IDLE.
  - A mem_ack in that same cycle takes precedence; no error is raised.
- A requester that still holds req in the cycle after ready is making a new request. Arbitration repeats in IDLE.
- Reset (asynchronous, mid-transaction included) forces the following immediately:
  - state IDLE
  - mem_req/mem_we 0, mem_addr/mem_wdata 0
  - i_ready/d_ready 0, busy 0, grant_d 0, err 0
  - starve_cnt 0, wait_cnt 0
  - The aborted transaction is dropped. Requesters re-present it after reset.

## Timing
- Grant decision is registered at the IDLE clock edge. mem_req rises one cycle after the request is seen in IDLE.
- Minimum latency: req in cycle 0, ready in cycle 1 (when mem_ack returns in the first BUSY cycle). In general ready arrives in cycle 1+W, where W is the number of memory wait cycles.
- Back-to-back throughput is one transaction per 2+W cycles (one IDLE cycle between transactions).
- i_ready, d_ready, i_rdata, d_rdata, stall_F and stall_M are combinational from state, mem_ack, mem_rdata and req.
- All mem_* outputs are registered.
- Timeout fires in the cycle when wait_cnt == TIMEOUT, i.e. the TIMEOUT+1-th BUSY cycle without ack.

## Test plan
- Single fetch: i_req=1, i_addr=0x100, memory acks in the first BUSY cycle with 0x00500093.
  - i_ready pulses in cycle 1 with i_rdata = 0x00500093.
  - stall_F is high in cycle 0 only.
- Simultaneous requests: d_req write (addr 0x200, data 0xDEADBEEF) and i_req read arrive together.
  - D is served first with mem_we = 1.
  - I is served after D's ready plus one IDLE cycle.
- Starvation: d_req and i_req held continuously, STARVE_LIMIT = 4, each ack after 1 wait cycle.
  - Grant sequence is D,D,D,D,I,D,D,D,D,I.
- Timeout: TIMEOUT = 3, d_req read, mem_ack never asserted.
  - d_ready pulses on the 4th BUSY cycle with d_rdata = 0.
  - err = 1 and stays 1.
  - A later transaction completes normally with err still 1.
- Reset mid-transaction: assert reset low during BUSY_D with mem_req = 1.
  - mem_req, busy and grant_d go to 0 without waiting for a clock edge.
  - After release with d_req held, the transaction restarts from IDLE.
- Ack in the same cycle as timeout: mem_ack arrives in the cycle with wait_cnt == TIMEOUT.
  - ready is returned with mem_rdata and err stays 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by fetch (I) and memory-stage (D) requesters.
// Data side has priority; a starvation counter forces an I grant, a watchdog ends hung transactions.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_F,
  output logic              stall_M,
  output logic              busy,
  output logic              grant_d,
  output logic              err
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t          state, state_next;
  logic [SW-1:0]   starve_cnt;
  logic [WW-1:0]   wait_cnt;
  logic            starve_hit, grant_d_now, grant_i_now, wd_hit, done, timed_out;

  assign starve_hit  = (starve_cnt == SW'(STARVE_LIMIT));
  assign grant_d_now = (state == IDLE) && d_req && !(i_req && starve_hit);
  assign grant_i_now = (state == IDLE) && i_req && !grant_d_now;
  assign wd_hit      = (wait_cnt == WW'(TIMEOUT));
  assign done        = (state != IDLE) && (mem_ack || wd_hit);
  // An ack arriving in the watchdog cycle wins: completion is normal, no error.
  assign timed_out   = (state != IDLE) && !mem_ack && wd_hit;
  assign busy        = (state != IDLE);
  assign stall_F     = i_req & ~i_ready;
  assign stall_M     = d_req & ~d_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    i_ready    = 1'b0;
    d_ready    = 1'b0;
    i_rdata    = '0;
    d_rdata    = '0;
    unique case (state)
      IDLE: begin
        if (grant_d_now)      state_next = BUSY_D;
        else if (grant_i_now) state_next = BUSY_I;
      end
      BUSY_I: begin
        if (done) begin
          i_ready    = 1'b1;
          i_rdata    = mem_ack ? mem_rdata : '0;
          state_next = IDLE;
        end
      end
      BUSY_D: begin
        if (done) begin
          d_ready    = 1'b1;
          d_rdata    = (mem_ack && !mem_we) ? mem_rdata : '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      grant_d    <= 1'b0;
      err        <= 1'b0;
      starve_cnt <= '0;
      wait_cnt   <= '0;
    end else if (grant_d_now) begin
      mem_req   <= 1'b1;
      mem_we    <= d_we;
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
      grant_d   <= 1'b1;
      wait_cnt  <= '0;
      if (!i_req)          starve_cnt <= '0;
      else if (!starve_hit) starve_cnt <= starve_cnt + SW'(1);
    end else if (grant_i_now) begin
      mem_req    <= 1'b1;
      mem_we     <= 1'b0;
      mem_addr   <= i_addr;
      mem_wdata  <= '0;
      grant_d    <= 1'b0;
      wait_cnt   <= '0;
      starve_cnt <= '0;
    end else if (done) begin
      mem_req <= 1'b0;
      if (timed_out) err <= 1'b1;
    end else if (state != IDLE) begin
      wait_cnt <= wait_cnt + WW'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, simultaneous, starvation, timeout, reset, ack-at-timeout.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_ready, d_ready, mem_req, mem_we, stall_F, stall_M, busy, grant_d, err;

  int total = 0;
  int bad   = 0;

  logic exp_g [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT(3)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_F(stall_F), .stall_M(stall_M), .busy(busy), .grant_d(grant_d), .err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant_d", 32'(grant_d), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_ready", {30'd0, i_ready, d_ready}, 0);
    tick();
    reset = 1'b1;

    // single fetch
    tick();
    i_req = 1'b1; i_addr = 32'h100; #1;
    chk("f_stallF_c0", 32'(stall_F), 1);
    chk("f_memreq_c0", 32'(mem_req), 0);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h0050_0093; #1;
    chk("f_memaddr", mem_addr, 32'h100);
    chk("f_memwe", 32'(mem_we), 0);
    chk("f_iready", 32'(i_ready), 1);
    chk("f_irdata", i_rdata, 32'h0050_0093);
    chk("f_stallF_c1", 32'(stall_F), 0);
    tick();
    i_req = 1'b0; mem_ack = 1'b0; #1;
    chk("f_idle", {30'd0, busy, mem_req}, 0);

    // simultaneous: D write first, I after an IDLE cycle
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
    i_req = 1'b1; i_addr = 32'h104; #1;
    chk("s_stalls", {30'd0, stall_F, stall_M}, 32'h3);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678; #1;
    chk("s_d_grant", 32'(grant_d), 1);
    chk("s_d_we", 32'(mem_we), 1);
    chk("s_d_addr", mem_addr, 32'h200);
    chk("s_d_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("s_d_ready", {30'd0, i_ready, d_ready}, 32'h1);
    chk("s_d_rdata", d_rdata, 0);
    chk("s_stallF", 32'(stall_F), 1);
    tick();
    d_req = 1'b0; mem_ack = 1'b0; #1;
    chk("s_gap_idle", 32'(busy), 0);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001; #1;
    chk("s_i_grant", 32'(grant_d), 0);
    chk("s_i_addr", mem_addr, 32'h104);
    chk("s_i_wdata", mem_wdata, 0);
    chk("s_i_ready", {30'd0, i_ready, d_ready}, 32'h2);
    chk("s_i_rdata", i_rdata, 32'hCAFE_0001);
    tick();
    i_req = 1'b0; mem_ack = 1'b0;

    // starvation: both requests held, one wait cycle each
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; i_req = 1'b1; i_addr = 32'h108;
    for (int k = 0; k < 10; k++) begin
      mem_ack = 1'b0; #1;
      chk($sformatf("st_idle_%0d", k), 32'(busy), 0);
      tick();
      chk($sformatf("st_grant_%0d", k), 32'(grant_d), 32'(exp_g[k]));
      chk($sformatf("st_wait_%0d", k), {30'd0, i_ready, d_ready}, 0);
      tick();
      mem_ack = 1'b1; mem_rdata = 32'(k); #1;
      chk($sformatf("st_ready_%0d", k), {30'd0, i_ready, d_ready}, exp_g[k] ? 32'h1 : 32'h2);
      tick();
    end
    d_req = 1'b0; i_req = 1'b0; mem_ack = 1'b0;

    // timeout on a D read
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk($sformatf("to_noready_%0d", c), {30'd0, d_ready, err}, 0);
    end
    tick();
    chk("to_ready", 32'(d_ready), 1);
    chk("to_rdata", d_rdata, 0);
    tick();
    d_req = 1'b0; i_req = 1'b1; i_addr = 32'h10C; #1;
    chk("to_err", 32'(err), 1);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h55; #1;
    chk("to_after_ready", 32'(i_ready), 1);
    chk("to_after_rdata", i_rdata, 32'h55);
    tick();
    i_req = 1'b0; mem_ack = 1'b0; #1;
    chk("to_err_sticky", 32'(err), 1);

    // asynchronous reset mid-transaction
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'h11;
    tick();
    chk("r_busy_before", {30'd0, busy, mem_req}, 32'h3);
    #2 reset = 1'b0; #1;
    chk("r_async", {28'd0, mem_req, busy, grant_d, err}, 0);
    chk("r_addr", mem_addr, 0);
    tick();
    reset = 1'b1; #1;
    chk("r_idle", 32'(busy), 0);
    tick();
    chk("r_restart", {29'd0, mem_req, mem_we, grant_d}, 32'h7);
    chk("r_restart_addr", mem_addr, 32'h500);
    mem_ack = 1'b1; #1;
    chk("r_ready", 32'(d_ready), 1);
    tick();
    d_req = 1'b0; mem_ack = 1'b0;

    // ack in the watchdog cycle
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    tick(); tick(); tick();
    chk("at_noready", 32'(d_ready), 0);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_A5A5; #1;
    chk("at_ready", 32'(d_ready), 1);
    chk("at_rdata", d_rdata, 32'hA5A5_A5A5);
    tick();
    d_req = 1'b0; mem_ack = 1'b0; #1;
    chk("at_err", 32'(err), 0);
    chk("at_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog sim_time observed=timeout expected=finish");
    $fatal(1, "bench time limit");
  end

endmodule
